ddr3_init_refresh_seq: RTL and testbench

Command-side driver for the DDR3 pin bundle (mem_a, mem_ba, mem_ck-domain controls, mem_odt, mem_reset_n) consumed by the board-level DDR3 memory wrapper. It performs the JEDEC power-up/initialization sequence (RESET#, CKE, MR2/MR3/MR1/MR0, ZQCL) and then issues periodic refresh (PREA + REF) under a request/grant handshake with the user datapath. All timings are in clk cycles, with simulation-friendly defaults.

---
 rtl/ddr3_init_refresh_seq.sv | 195 +++++++++++++++++++
 tb/tb_ddr3_init_refresh_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_refresh_seq.sv
// DDR3 power-up/initialisation sequencer and periodic refresh engine.
// Owns the command bus during init and during each PREA+REF refresh pair.
module ddr3_init_refresh_seq #(
    parameter int MEM_A_WIDTH = 15,
    parameter int T_RESET     = 200,
    parameter int T_CKE       = 500,
    parameter int T_XPR       = 64,
    parameter int T_MRD       = 4,
    parameter int T_MOD       = 12,
    parameter int T_ZQINIT    = 512,
    parameter int T_RP        = 6,
    parameter int T_RFC       = 64,
    parameter int T_REFI      = 3120,
    parameter logic [MEM_A_WIDTH-1:0] MR0_VAL = 15'h0520,
    parameter logic [MEM_A_WIDTH-1:0] MR1_VAL = 15'h0004,
    parameter logic [MEM_A_WIDTH-1:0] MR2_VAL = 15'h0008,
    parameter logic [MEM_A_WIDTH-1:0] MR3_VAL = 15'h0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ref_gnt,
    output logic                   init_done,
    output logic                   ref_req,
    output logic                   busy,
    output logic                   mem_reset_n,
    output logic                   mem_cke,
    output logic                   mem_cs_n,
    output logic                   mem_ras_n,
    output logic                   mem_cas_n,
    output logic                   mem_we_n,
    output logic [2:0]             mem_ba,
    output logic [MEM_A_WIDTH-1:0] mem_a,
    output logic                   mem_odt
);

    typedef enum logic [3:0] {
        S_RST_LOW, S_CKE_WAIT, S_XPR_WAIT,
        S_MRS2, S_MRS3, S_MRS1, S_MRS0,
        S_MOD_WAIT, S_ZQCL, S_ZQ_WAIT,
        S_IDLE, S_PREA, S_REF
    } state_e;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;
    localparam logic [3:0] CMD_PREA = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;

    state_e                 state_q, state_d;
    logic [19:0]            cnt_q, cnt_d;
    logic [19:0]            tmr_q, tmr_d;
    logic [3:0]             pending_q, pending_d;
    logic [3:0]             cmd_q, cmd_d;
    logic [2:0]             ba_q, ba_d;
    logic [MEM_A_WIDTH-1:0] a_q, a_d;
    logic                   reset_n_q, reset_n_d;
    logic                   cke_q, cke_d;
    logic                   init_done_q, init_done_d;
    logic                   ref_req_q, ref_req_d;
    logic                   busy_q, busy_d;
    logic                   done, expire, dec;

    // Residency of each state, counted from its command/entry cycle.
    function automatic logic [19:0] load_val(input state_e s);
        logic [19:0] v;
        v = 20'd0;
        case (s)
            S_CKE_WAIT: v = 20'(T_CKE - 1);
            S_XPR_WAIT: v = 20'(T_XPR - 1);
            S_MRS2,
            S_MRS3,
            S_MRS1:     v = 20'(T_MRD - 1);
            S_MOD_WAIT: v = 20'(T_MOD - 2);
            S_ZQ_WAIT:  v = 20'(T_ZQINIT - 2);
            S_PREA:     v = 20'(T_RP - 1);
            S_REF:      v = 20'(T_RFC - 1);
            default:    v = 20'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d = state_q;
        done    = (cnt_q == 20'd0);
        case (state_q)
            S_RST_LOW:  if (done) state_d = S_CKE_WAIT;
            S_CKE_WAIT: if (done) state_d = S_XPR_WAIT;
            S_XPR_WAIT: if (done) state_d = S_MRS2;
            S_MRS2:     if (done) state_d = S_MRS3;
            S_MRS3:     if (done) state_d = S_MRS1;
            S_MRS1:     if (done) state_d = S_MRS0;
            S_MRS0:     if (done) state_d = S_MOD_WAIT;
            S_MOD_WAIT: if (done) state_d = S_ZQCL;
            S_ZQCL:     if (done) state_d = S_ZQ_WAIT;
            S_ZQ_WAIT:  if (done) state_d = S_IDLE;
            S_IDLE:     if (ref_req_q && ref_gnt) state_d = S_PREA;
            S_PREA:     if (done) state_d = S_REF;
            S_REF:      if (done) state_d = S_IDLE;
            default:    state_d = S_RST_LOW;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = load_val(state_d);
        end else if (cnt_q != 20'd0) begin
            cnt_d = cnt_q - 20'd1;
        end
    end

    // Commands fire only on the cycle a command state is entered.
    always_comb begin
        cmd_d = CMD_NOP;
        ba_d  = 3'd0;
        a_d   = '0;
        if (state_d != state_q) begin
            case (state_d)
                S_MRS2: begin cmd_d = CMD_MRS; ba_d = 3'd2; a_d = MR2_VAL; end
                S_MRS3: begin cmd_d = CMD_MRS; ba_d = 3'd3; a_d = MR3_VAL; end
                S_MRS1: begin cmd_d = CMD_MRS; ba_d = 3'd1; a_d = MR1_VAL; end
                S_MRS0: begin cmd_d = CMD_MRS; ba_d = 3'd0; a_d = MR0_VAL; end
                S_ZQCL: begin cmd_d = CMD_ZQCL; a_d[10] = 1'b1; end
                S_PREA: begin cmd_d = CMD_PREA; a_d[10] = 1'b1; end
                S_REF:  cmd_d = CMD_REF;
                default: cmd_d = CMD_NOP;
            endcase
        end
    end

    always_comb begin
        reset_n_d   = reset_n_q | (state_d == S_CKE_WAIT);
        cke_d       = cke_q | (state_d == S_XPR_WAIT);
        init_done_d = init_done_q | (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        expire      = init_done_q && (tmr_q == 20'd0);
        dec         = (state_q == S_PREA) && (state_d == S_REF);
        tmr_d       = tmr_q - 20'd1;
        if (!init_done_q || tmr_q == 20'd0) begin
            tmr_d = 20'(T_REFI - 1);
        end
        // Simultaneous expiry and REF cancel out.
        pending_d = pending_q;
        if (expire && !dec && pending_q != 4'd8) begin
            pending_d = pending_q + 4'd1;
        end else if (!expire && dec) begin
            pending_d = pending_q - 4'd1;
        end
        ref_req_d = (pending_d != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST_LOW;
            cnt_q       <= 20'(T_RESET - 1);
            tmr_q       <= 20'(T_REFI - 1);
            pending_q   <= 4'd0;
            cmd_q       <= CMD_NOP;
            ba_q        <= 3'd0;
            a_q         <= '0;
            reset_n_q   <= 1'b0;
            cke_q       <= 1'b0;
            init_done_q <= 1'b0;
            ref_req_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            pending_q   <= pending_d;
            cmd_q       <= cmd_d;
            ba_q        <= ba_d;
            a_q         <= a_d;
            reset_n_q   <= reset_n_d;
            cke_q       <= cke_d;
            init_done_q <= init_done_d;
            ref_req_q   <= ref_req_d;
            busy_q      <= busy_d;
        end
    end

    assign init_done   = init_done_q;
    assign ref_req     = ref_req_q;
    assign busy        = busy_q;
    assign mem_reset_n = reset_n_q;
    assign mem_cke     = cke_q;
    assign mem_cs_n    = cmd_q[3];
    assign mem_ras_n   = cmd_q[2];
    assign mem_cas_n   = cmd_q[1];
    assign mem_we_n    = cmd_q[0];
    assign mem_ba      = ba_q;
    assign mem_a       = a_q;
    assign mem_odt     = 1'b0;

endmodule

// File: tb/tb_ddr3_init_refresh_seq.sv
// Bench for ddr3_init_refresh_seq: a timeline model predicts status and
// commands per cycle; a negedge monitor pops and compares them.
module tb_ddr3_init_refresh_seq;

    localparam int T_RESET  = 4;
    localparam int T_CKE    = 5;
    localparam int T_XPR    = 3;
    localparam int T_MRD    = 4;
    localparam int T_MOD    = 6;
    localparam int T_ZQINIT = 8;
    localparam int T_RP     = 2;
    localparam int T_RFC    = 5;
    localparam int T_REFI   = 20;
    localparam logic [14:0] MR0 = 15'h0520;
    localparam logic [14:0] MR1 = 15'h0004;
    localparam logic [14:0] MR2 = 15'h0008;
    localparam logic [14:0] MR3 = 15'h0000;
    localparam logic [14:0] A10 = 15'h0400;
    localparam int M0 = T_RESET + T_CKE + T_XPR;
    localparam int ZQ = M0 + 3 * T_MRD + T_MOD;
    localparam int D  = ZQ + T_ZQINIT;

    typedef struct {
        int          t;
        logic [3:0]  cmd;
        logic [2:0]  ba;
        logic [14:0] a;
    } cmd_t;

    typedef struct {
        int   t;
        logic rn;
        logic cke;
        logic done;
        logic req;
        logic busy;
    } stat_t;

    logic        clk, rst, ref_gnt;
    logic        init_done, ref_req, busy;
    logic        mem_reset_n, mem_cke, mem_odt;
    logic        mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n;
    logic [2:0]  mem_ba;
    logic [14:0] mem_a;

    cmd_t  exp_cmd[$];
    stat_t exp_stat[$];
    int    vectors, miscompares, ref_seen;

    ddr3_init_refresh_seq #(
        .MEM_A_WIDTH(15), .T_RESET(T_RESET), .T_CKE(T_CKE),
        .T_XPR(T_XPR), .T_MRD(T_MRD), .T_MOD(T_MOD),
        .T_ZQINIT(T_ZQINIT), .T_RP(T_RP), .T_RFC(T_RFC),
        .T_REFI(T_REFI), .MR0_VAL(MR0), .MR1_VAL(MR1),
        .MR2_VAL(MR2), .MR3_VAL(MR3)
    ) dut (
        .clk(clk), .rst(rst), .ref_gnt(ref_gnt),
        .init_done(init_done), .ref_req(ref_req), .busy(busy),
        .mem_reset_n(mem_reset_n), .mem_cke(mem_cke),
        .mem_cs_n(mem_cs_n), .mem_ras_n(mem_ras_n),
        .mem_cas_n(mem_cas_n), .mem_we_n(mem_we_n),
        .mem_ba(mem_ba), .mem_a(mem_a), .mem_odt(mem_odt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        stat_t      s;
        cmd_t       c;
        logic [3:0] cmd;
        if (exp_stat.size() != 0) begin
            s   = exp_stat.pop_front();
            cmd = {mem_cs_n, mem_ras_n, mem_cas_n, mem_we_n};
            vectors++;
            if ({mem_reset_n, mem_cke, init_done, ref_req, busy, mem_odt} !==
                {s.rn, s.cke, s.done, s.req, s.busy, 1'b0}) begin
                miscompares++;
                $display("FAIL status t=%0d got rn=%b cke=%b done=%b req=%b busy=%b odt=%b exp rn=%b cke=%b done=%b req=%b busy=%b odt=0",
                         s.t, mem_reset_n, mem_cke, init_done, ref_req, busy, mem_odt,
                         s.rn, s.cke, s.done, s.req, s.busy);
            end
            if (cmd === 4'b0001) ref_seen++;
            while (exp_cmd.size() != 0 && exp_cmd[0].t < s.t) begin
                c = exp_cmd.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missed_cmd t=%0d got none exp cmd=%b", c.t, c.cmd);
            end
            if (exp_cmd.size() != 0 && exp_cmd[0].t == s.t) begin
                c = exp_cmd.pop_front();
                vectors++;
                if ({cmd, mem_ba, mem_a} !== {c.cmd, c.ba, c.a}) begin
                    miscompares++;
                    $display("FAIL cmd t=%0d got cmd=%b ba=%0d a=%h exp cmd=%b ba=%0d a=%h",
                             s.t, cmd, mem_ba, mem_a, c.cmd, c.ba, c.a);
                end
            end else if (cmd !== 4'b0111 || mem_ba !== 3'd0 || mem_a !== 15'd0) begin
                vectors++;
                miscompares++;
                $display("FAIL nop t=%0d got cmd=%b ba=%0d a=%h exp cmd=0111 ba=0 a=0",
                         s.t, cmd, mem_ba, mem_a);
            end
        end
    end

    function automatic logic gnt_of(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t >= D + 100);
            2:       return (t >= D + 200);
            3:       return (t == D + 37);
            default: return ($urandom_range(0, 3) == 0);
        endcase
    endfunction

    task automatic run_phase(input int len, input int mode, input int rst_at);
        int   pend, free_at, ref_at, refs, stop;
        logic g, inc, dec;
        @(posedge clk);
        #1 rst = 1'b0;
        pend = 0; free_at = D; ref_at = -1; refs = 0; ref_seen = 0;
        stop = (rst_at >= 0) ? rst_at : len;
        exp_cmd.push_back('{M0,             4'b0000, 3'd2, MR2});
        exp_cmd.push_back('{M0 + T_MRD,     4'b0000, 3'd3, MR3});
        exp_cmd.push_back('{M0 + 2 * T_MRD, 4'b0000, 3'd1, MR1});
        exp_cmd.push_back('{M0 + 3 * T_MRD, 4'b0000, 3'd0, MR0});
        exp_cmd.push_back('{ZQ,             4'b0110, 3'd0, A10});
        for (int t = 0; t < len; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            g = gnt_of(mode, t);
            ref_gnt = g;
            if (t == rst_at) begin
                exp_stat.push_back('{t, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
                #1 rst = 1'b1;
                exp_cmd.delete();
                break;
            end
            exp_stat.push_back('{t, (t >= T_RESET), (t >= T_RESET + T_CKE),
                                 (t >= D), (pend != 0), (t < free_at)});
            if (t >= D) begin
                if (t >= free_at && pend != 0 && g) begin
                    exp_cmd.push_back('{t + 1, 4'b0010, 3'd0, A10});
                    exp_cmd.push_back('{t + 1 + T_RP, 4'b0001, 3'd0, 15'd0});
                    ref_at  = t + 1 + T_RP;
                    free_at = ref_at + T_RFC;
                    if (ref_at < stop) refs++;
                end
                inc = (((t - D) % T_REFI) == T_REFI - 1);
                dec = (ref_at == t + 1);
                if (inc && !dec) pend = (pend < 8) ? pend + 1 : 8;
                else if (dec && !inc) pend = pend - 1;
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (ref_seen != refs) begin
            miscompares++;
            $display("FAIL ref_count mode=%0d got %0d exp %0d", mode, ref_seen, refs);
        end
        if (rst_at < 0) begin
            @(posedge clk);
            #2 rst = 1'b1;
            exp_cmd.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        ref_gnt = 1'b0;
        vectors = 0;
        miscompares = 0;
        ref_seen = 0;
        repeat (2) @(posedge clk);
        run_phase(120, 0, -1);
        run_phase(40, 0, M0 + 2 * T_MRD + 2);
        run_phase(D + 200, 1, -1);
        run_phase(D + 320, 2, -1);
        run_phase(120, 3, -1);
        run_phase(100, 0, D + 25);
        run_phase(400, 4, -1);
        run_phase(300, 4, -1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
